mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage directly downstream of the EX/MEM pipeline register; consumes its outputs.
- Performs data-memory load/store at address alu_result, holds store data from data_2, and resolves the PC redirect toward fetch.
- Contains the MEM/WB pipeline register feeding writeback.
- Supports configurable multi-cycle memory latency, with a stall handshake back to the upstream stages.

Parameters:
- MEM_LATENCY, 1: cycles per data-memory access; legal range 1..15.
- DEPTH, 256: data memory words; addressed by the full 8-bit alu_result.

Ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_new_branch_pc  in  12  branch/jump target from EX/MEM.
- in_alu_result  in  8  ALU result; also the memory address.
- in_data_2  in  8  store data.
- in_reg_write  in  3  destination register index.
- in_MEM_mem_read_write  in  1  1 = store, 0 = no store.
- in_MEM_pc_src  in  2  00 = sequential, 01 = branch taken, 10 = jump, 11 = reserved.
- in_WB_mem_or_alu  in  1  1 = writeback from memory (load), 0 = from ALU.
- in_WB_reg_write_signal  in  1  register-file write enable.
- stall  out  1  upstream must hold the EX/MEM contents while high.
- out_pc_src  out  2  redirect select to fetch.
- out_branch_pc  out  12  redirect target.
- out_mem_data  out  8  MEM/WB: load data.
- out_alu_result  out  8  MEM/WB: ALU result.
- out_reg_write  out  3  MEM/WB: destination register.
- out_WB_mem_or_alu  out  1  MEM/WB: writeback select.
- out_WB_reg_write_signal  out  1  MEM/WB: register write enable.

Behaviour:
- Access decode:
  - access = store | load.
  - store = in_MEM_mem_read_write.
  - load = in_WB_mem_or_alu & ~in_MEM_mem_read_write.
- Reset (rst_n low, asynchronous):
  - All MEM/WB outputs 0; FSM to IDLE; counter to 0.
  - stall and out_pc_src are 0 while in reset.
  - Memory contents are not reset.
- FSM states: IDLE, BUSY. 4-bit down-counter cnt.
- IDLE, no access, or MEM_LATENCY == 1:
  - Instruction completes this cycle; stall = 0.
  - On the rising edge: store commits mem[alu_result] <= data_2; MEM/WB captures all fields.
  - out_mem_data = mem[alu_result] (read before any same-edge write; a store's out_mem_data is don't-care).
- IDLE, access, MEM_LATENCY > 1:
  - stall = 1; go BUSY with cnt = MEM_LATENCY-2.
  - MEM/WB captures a bubble: out_WB_reg_write_signal = 0, other fields 0.
  - No memory write.
- BUSY, cnt != 0: stall = 1; cnt decrements; MEM/WB captures a bubble.
- BUSY, cnt == 0:
  - stall = 0; completing cycle, identical to the single-cycle completion above.
  - Return to IDLE.
- Per-access timing:
  - Occupancy is exactly MEM_LATENCY cycles; stall is high for exactly MEM_LATENCY-1 consecutive cycles.
  - A store writes exactly once, on the completing edge only.
- Redirect: combinational.
  - out_branch_pc = in_new_branch_pc.
  - out_pc_src = in_MEM_pc_src when stall = 0, else 00, so a redirect is issued exactly once.
  - in_MEM_pc_src = 11 maps to out_pc_src = 00.
- MEM/WB latency: 1 clock after the completing cycle.
- Back-to-back behaviour:
  - A store followed by a load to the same address returns the new data (write commits on the edge before the load completes).
  - Back-to-back accesses each pay the full MEM_LATENCY; no overlap.
- Inputs are sampled only in the completing cycle. Upstream must hold them stable during stall; changes while stalled are ignored except on the completing cycle.
- Reset asserted mid-BUSY aborts the access; a pending store is discarded.

Decomposition:
- Shared package (pipeline_pkg):
  - PC_W = 12, DATA_W = 8, REG_IDX_W = 3.
  - pc_src encodings PC_SEQ/PC_BRANCH/PC_JUMP/PC_RSVD.
  - mem_state_t enum {IDLE, BUSY}.
- One sub-module data_mem:
  - DEPTH x 8 array; combinational read, synchronous write with write enable; no reset.
- FSM, counter, redirect logic and the MEM/WB register live in mem_stage.

Test Plan:
- MEM_LATENCY = 1:
  - Store data_2 = 0x5A at alu_result = 0x10.
  - Next, load 0x10 with reg_write = 3, reg_write_signal = 1.
  - Required: the following cycle shows out_mem_data = 0x5A, out_reg_write = 3, out_WB_mem_or_alu = 1; stall never high.
- MEM_LATENCY = 3, store 0x33 to 0x20:
  - stall high exactly 2 cycles; out_WB_reg_write_signal = 0 during those cycles.
  - A later load of 0x20 returns 0x33; the write occurs once.
- MEM_LATENCY = 3, ALU op (mem_or_alu = 0, read_write = 0), alu_result = 0x7F:
  - No stall; out_alu_result = 0x7F one cycle later.
- Branch redirect:
  - pc_src = 01, new_branch_pc = 0xABC with no access: same-cycle out_pc_src = 01, out_branch_pc = 0xABC.
  - With MEM_LATENCY = 3 on a load carrying pc_src = 01: out_pc_src = 00 for 2 cycles, then 01 for exactly 1 cycle.
  - pc_src = 11 gives out_pc_src = 00.
- Reset mid-operation:
  - Drop rst_n during the second stall cycle of a store of 0xFF to 0x05.
  - Required: outputs 0 immediately, stall = 0; a subsequent load of 0x05 returns the prior value, not 0xFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared widths, PC-source encodings and MEM-stage FSM state type for the pipeline.
package pipeline_pkg;

    localparam int unsigned PC_W      = 12;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned REG_IDX_W = 3;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RSVD   = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/data_mem.sv
// Data memory: combinational read, synchronous write; contents survive reset.
module data_mem
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [7:0]        i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage.sv
// Memory stage: multi-cycle data access with upstream stall, PC redirect and MEM/WB register.
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned DEPTH       = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PC_W-1:0]      in_new_branch_pc,
    input  logic [DATA_W-1:0]    in_alu_result,
    input  logic [DATA_W-1:0]    in_data_2,
    input  logic [REG_IDX_W-1:0] in_reg_write,
    input  logic                 in_MEM_mem_read_write,
    input  logic [1:0]           in_MEM_pc_src,
    input  logic                 in_WB_mem_or_alu,
    input  logic                 in_WB_reg_write_signal,
    output logic                 stall,
    output logic [1:0]           out_pc_src,
    output logic [PC_W-1:0]      out_branch_pc,
    output logic [DATA_W-1:0]    out_mem_data,
    output logic [DATA_W-1:0]    out_alu_result,
    output logic [REG_IDX_W-1:0] out_reg_write,
    output logic                 out_WB_mem_or_alu,
    output logic                 out_WB_reg_write_signal
);

    localparam bit         MULTI_CYCLE = (MEM_LATENCY > 1);
    localparam logic [3:0] CNT_INIT    = MULTI_CYCLE ? 4'(MEM_LATENCY - 2) : 4'd0;

    mem_state_t r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;

    logic w_store, w_load, w_access;
    logic w_busy_stall, w_complete, w_mem_we;
    logic [DATA_W-1:0] w_rdata;

    logic [DATA_W-1:0]    r_mem_data;
    logic [DATA_W-1:0]    r_alu_result;
    logic [REG_IDX_W-1:0] r_reg_write;
    logic                 r_mem_or_alu;
    logic                 r_reg_write_signal;

    assign w_store  = in_MEM_mem_read_write;
    assign w_load   = in_WB_mem_or_alu & ~in_MEM_mem_read_write;
    assign w_access = w_store | w_load;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_busy_stall = 1'b0;
        w_complete   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_access && MULTI_CYCLE) begin
                    w_busy_stall = 1'b1;
                    w_state_nxt  = BUSY;
                    w_cnt_nxt    = CNT_INIT;
                end else begin
                    w_complete = 1'b1;
                end
            end
            BUSY: begin
                if (r_cnt != 4'd0) begin
                    w_busy_stall = 1'b1;
                    w_cnt_nxt    = r_cnt - 4'd1;
                end else begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Stalled cycles suppress the redirect so fetch sees it exactly once, on completion.
    assign stall         = rst_n & w_busy_stall;
    assign out_branch_pc = in_new_branch_pc;
    assign out_pc_src    = (!rst_n || w_busy_stall || in_MEM_pc_src == PC_RSVD) ? PC_SEQ
                                                                                 : in_MEM_pc_src;

    assign w_mem_we = rst_n & w_complete & w_store;

    data_mem #(
        .DEPTH (DEPTH)
    ) u_data_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (in_alu_result),
        .i_wdata (in_data_2),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_data         <= '0;
            r_alu_result       <= '0;
            r_reg_write        <= '0;
            r_mem_or_alu       <= 1'b0;
            r_reg_write_signal <= 1'b0;
        end else if (w_complete) begin
            r_mem_data         <= w_rdata;
            r_alu_result       <= in_alu_result;
            r_reg_write        <= in_reg_write;
            r_mem_or_alu       <= in_WB_mem_or_alu;
            r_reg_write_signal <= in_WB_reg_write_signal;
        end else begin
            r_mem_data         <= '0;
            r_alu_result       <= '0;
            r_reg_write        <= '0;
            r_mem_or_alu       <= 1'b0;
            r_reg_write_signal <= 1'b0;
        end
    end

    assign out_mem_data            = r_mem_data;
    assign out_alu_result          = r_alu_result;
    assign out_reg_write           = r_reg_write;
    assign out_WB_mem_or_alu       = r_mem_or_alu;
    assign out_WB_reg_write_signal = r_reg_write_signal;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: one single-cycle and one three-cycle instance on shared stimulus.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] in_new_branch_pc;
    logic [7:0]  in_alu_result;
    logic [7:0]  in_data_2;
    logic [2:0]  in_reg_write;
    logic        in_MEM_mem_read_write;
    logic [1:0]  in_MEM_pc_src;
    logic        in_WB_mem_or_alu;
    logic        in_WB_reg_write_signal;

    logic        d1_stall, d3_stall;
    logic [1:0]  d1_pc_src, d3_pc_src;
    logic [11:0] d1_bpc, d3_bpc;
    logic [7:0]  d1_md, d3_md, d1_alu, d3_alu;
    logic [2:0]  d1_rd, d3_rd;
    logic        d1_mor, d3_mor, d1_wen, d3_wen;

    always #5 clk = ~clk;

    mem_stage #(.MEM_LATENCY(1), .DEPTH(256)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_new_branch_pc(in_new_branch_pc),
        .in_alu_result(in_alu_result), .in_data_2(in_data_2), .in_reg_write(in_reg_write),
        .in_MEM_mem_read_write(in_MEM_mem_read_write), .in_MEM_pc_src(in_MEM_pc_src),
        .in_WB_mem_or_alu(in_WB_mem_or_alu), .in_WB_reg_write_signal(in_WB_reg_write_signal),
        .stall(d1_stall), .out_pc_src(d1_pc_src), .out_branch_pc(d1_bpc),
        .out_mem_data(d1_md), .out_alu_result(d1_alu), .out_reg_write(d1_rd),
        .out_WB_mem_or_alu(d1_mor), .out_WB_reg_write_signal(d1_wen)
    );

    mem_stage #(.MEM_LATENCY(3), .DEPTH(256)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_new_branch_pc(in_new_branch_pc),
        .in_alu_result(in_alu_result), .in_data_2(in_data_2), .in_reg_write(in_reg_write),
        .in_MEM_mem_read_write(in_MEM_mem_read_write), .in_MEM_pc_src(in_MEM_pc_src),
        .in_WB_mem_or_alu(in_WB_mem_or_alu), .in_WB_reg_write_signal(in_WB_reg_write_signal),
        .stall(d3_stall), .out_pc_src(d3_pc_src), .out_branch_pc(d3_bpc),
        .out_mem_data(d3_md), .out_alu_result(d3_alu), .out_reg_write(d3_rd),
        .out_WB_mem_or_alu(d3_mor), .out_WB_reg_write_signal(d3_wen)
    );

    typedef struct packed {
        logic [7:0] md;
        logic [7:0] alu;
        logic [2:0] rd;
        logic       mor;
        logic       wen;
    } wb_t;

    typedef struct packed {
        logic chk_md;
        wb_t  wb;
    } exp_t;

    exp_t sb[$];
    wb_t  act1, act3;
    int   n_pass = 0;
    int   n_total = 0;

    always_comb act1 = {d1_md, d1_alu, d1_rd, d1_mor, d1_wen};
    always_comb act3 = {d3_md, d3_alu, d3_rd, d3_mor, d3_wen};

    // Load data of a store (or of an unprimed address) is don't-care.
    function automatic wb_t masked(input wb_t w, input logic chk_md);
        wb_t r;
        r = w;
        if (!chk_md) r.md = 8'h00;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rw, input logic mor, input logic [7:0] addr,
                          input logic [7:0] data, input logic [2:0] rd, input logic wen,
                          input logic [1:0] pcs, input logic [11:0] bpc);
        in_MEM_mem_read_write  = rw;
        in_WB_mem_or_alu       = mor;
        in_alu_result          = addr;
        in_data_2              = data;
        in_reg_write           = rd;
        in_WB_reg_write_signal = wen;
        in_MEM_pc_src          = pcs;
        in_new_branch_pc       = bpc;
    endtask

    task automatic set_idle();
        set_in(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 2'b00, 12'h000);
    endtask

    // Runs the three-cycle instance through one access, checking bubbles and stall length.
    task automatic run_access3(input string name, input exp_t e);
        int   n;
        exp_t got;
        wb_t  a;
        n = 0;
        #1;
        while (d3_stall === 1'b1 && n < 20) begin
            tick();
            n++;
            n_total++;
            if (d3_wen !== 1'b0) $display("FAIL %s bubble wen: got %b want 0", name, d3_wen);
            else n_pass++;
        end
        n_total++;
        if (n != 2) $display("FAIL %s stall cycles: got %0d want 2", name, n);
        else n_pass++;
        sb.push_back(e);
        tick();
        got = sb.pop_front();
        a = act3;
        n_total++;
        if (masked(a, got.chk_md) !== masked(got.wb, got.chk_md))
            $display("FAIL %s memwb: got %h want %h", name, masked(a, got.chk_md),
                     masked(got.wb, got.chk_md));
        else n_pass++;
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b0, 8'h40, 8'h99, 3'd7, 1'b1, 2'b01, 12'h111);
        #2;
        n_total++;
        if (d3_stall !== 1'b0) $display("FAIL reset stall: got %b want 0", d3_stall);
        else n_pass++;
        n_total++;
        if (d3_pc_src !== 2'b00) $display("FAIL reset pc_src: got %b want 00", d3_pc_src);
        else n_pass++;
        tick();
        n_total++;
        if (act3 !== '0 || act1 !== '0)
            $display("FAIL reset memwb: got %h/%h want 0", act1, act3);
        else n_pass++;
        set_idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lat1_store_load();
        exp_t got;
        set_in(1'b1, 1'b0, 8'h10, 8'h5A, 3'd0, 1'b0, 2'b00, 12'h000);
        #1;
        n_total++;
        if (d1_stall !== 1'b0) $display("FAIL lat1 store stall: got %b want 0", d1_stall);
        else n_pass++;
        sb.push_back('{chk_md: 1'b0, wb: '{md: 8'h00, alu: 8'h10, rd: 3'd0, mor: 1'b0, wen: 1'b0}});
        tick();
        got = sb.pop_front();
        n_total++;
        if (masked(act1, 1'b0) !== masked(got.wb, 1'b0))
            $display("FAIL lat1 store memwb: got %h want %h", act1, got.wb);
        else n_pass++;
        set_in(1'b0, 1'b1, 8'h10, 8'h00, 3'd3, 1'b1, 2'b00, 12'h000);
        #1;
        n_total++;
        if (d1_stall !== 1'b0) $display("FAIL lat1 load stall: got %b want 0", d1_stall);
        else n_pass++;
        sb.push_back('{chk_md: 1'b1, wb: '{md: 8'h5A, alu: 8'h10, rd: 3'd3, mor: 1'b1, wen: 1'b1}});
        tick();
        got = sb.pop_front();
        n_total++;
        if (act1 !== got.wb) $display("FAIL lat1 load memwb: got %h want %h", act1, got.wb);
        else n_pass++;
        set_idle();
        tick();
    endtask

    task automatic test_lat3_store_load();
        set_in(1'b1, 1'b0, 8'h20, 8'h33, 3'd2, 1'b1, 2'b00, 12'h000);
        run_access3("lat3 store",
            '{chk_md: 1'b0, wb: '{md: 8'h00, alu: 8'h20, rd: 3'd2, mor: 1'b0, wen: 1'b1}});
        set_in(1'b0, 1'b1, 8'h20, 8'h00, 3'd4, 1'b1, 2'b00, 12'h000);
        run_access3("lat3 load",
            '{chk_md: 1'b1, wb: '{md: 8'h33, alu: 8'h20, rd: 3'd4, mor: 1'b1, wen: 1'b1}});
        set_idle();
        tick();
    endtask

    task automatic test_alu_op();
        exp_t got;
        set_in(1'b0, 1'b0, 8'h7F, 8'h00, 3'd5, 1'b1, 2'b00, 12'h000);
        #1;
        n_total++;
        if (d3_stall !== 1'b0) $display("FAIL alu stall: got %b want 0", d3_stall);
        else n_pass++;
        sb.push_back('{chk_md: 1'b0, wb: '{md: 8'h00, alu: 8'h7F, rd: 3'd5, mor: 1'b0, wen: 1'b1}});
        tick();
        got = sb.pop_front();
        n_total++;
        if (masked(act3, 1'b0) !== masked(got.wb, 1'b0))
            $display("FAIL alu memwb: got %h want %h", act3, got.wb);
        else n_pass++;
        set_idle();
        tick();
    endtask

    task automatic test_branch();
        logic [1:0] pcs_tab [4];
        logic [1:0] exp_tab [4];
        pcs_tab = '{2'b00, 2'b01, 2'b10, 2'b11};
        exp_tab = '{2'b00, 2'b01, 2'b10, 2'b00};
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, pcs_tab[i], 12'hABC);
            #1;
            n_total++;
            if (d3_pc_src !== exp_tab[i] || d1_pc_src !== exp_tab[i])
                $display("FAIL branch pc_src[%0d]: got %b/%b want %b", i, d1_pc_src, d3_pc_src,
                         exp_tab[i]);
            else n_pass++;
            n_total++;
            if (d3_bpc !== 12'hABC) $display("FAIL branch pc: got %h want abc", d3_bpc);
            else n_pass++;
        end
        set_idle();
        tick();
    endtask

    task automatic test_branch_stall();
        logic [1:0] want;
        exp_t       got;
        set_in(1'b0, 1'b1, 8'h20, 8'h00, 3'd6, 1'b1, 2'b01, 12'h123);
        #1;
        for (int k = 0; k < 3; k++) begin
            want = (k < 2) ? 2'b00 : 2'b01;
            n_total++;
            if (d3_pc_src !== want)
                $display("FAIL branch stall pc_src[%0d]: got %b want %b", k, d3_pc_src, want);
            else n_pass++;
            if (k < 2) tick();
        end
        sb.push_back('{chk_md: 1'b1, wb: '{md: 8'h33, alu: 8'h20, rd: 3'd6, mor: 1'b1, wen: 1'b1}});
        tick();
        got = sb.pop_front();
        n_total++;
        if (act3 !== got.wb) $display("FAIL branch stall memwb: got %h want %h", act3, got.wb);
        else n_pass++;
        // Inputs still held: a fresh access begins, so the redirect must not repeat.
        n_total++;
        if (d3_pc_src !== 2'b00) $display("FAIL branch once: got %b want 00", d3_pc_src);
        else n_pass++;
        set_idle();
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 1'b0, 8'h05, 8'h11, 3'd0, 1'b0, 2'b00, 12'h000);
        run_access3("prime store",
            '{chk_md: 1'b0, wb: '{md: 8'h00, alu: 8'h05, rd: 3'd0, mor: 1'b0, wen: 1'b0}});
        set_idle();
        tick();
        set_in(1'b1, 1'b0, 8'h05, 8'hFF, 3'd1, 1'b1, 2'b01, 12'h000);
        tick();
        n_total++;
        if (d3_stall !== 1'b1) $display("FAIL mid stall before reset: got %b want 1", d3_stall);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (d3_stall !== 1'b0 || d3_pc_src !== 2'b00)
            $display("FAIL mid reset stall/pc_src: got %b/%b want 0/00", d3_stall, d3_pc_src);
        else n_pass++;
        n_total++;
        if (act3 !== '0) $display("FAIL mid reset memwb: got %h want 0", act3);
        else n_pass++;
        tick();
        set_idle();
        rst_n = 1'b1;
        tick();
        set_in(1'b0, 1'b1, 8'h05, 8'h00, 3'd1, 1'b1, 2'b00, 12'h000);
        run_access3("post reset load",
            '{chk_md: 1'b1, wb: '{md: 8'h11, alu: 8'h05, rd: 3'd1, mor: 1'b1, wen: 1'b1}});
        set_idle();
        tick();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_lat1_store_load();
        test_lat3_store_load();
        test_alu_op();
        test_branch();
        test_branch_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
